// File: rtl/bcd_disp_pkg.sv
// Shared types and active-low segment patterns for the BCD display path.
package bcd_disp_pkg;

  // Segment vector ordered {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;

  // Phase within a digit slot.
  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Display bus: packed BCD digits and controls in, multiplexed display pins out.
// master = digit source side, slave = scanner side.
interface bcd_seg_scanner_if
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    en;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    seg;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output digits, dp_in, en,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  digits, dp_in, en,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);

  // Digit pattern lookup
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver. Captures all digits once per
// frame, then lights one digit per slot after a guard interval with anodes off.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_seg_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  bcd_seg_scanner_if.slave  bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap_d;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic                    r_post_rst;
  logic [NUM_DIGITS-1:0]   r_an;
  seg_t                    r_seg;
  logic                    r_dp;
  logic                    r_frame_tick;

  logic                    w_slot_end;
  logic                    w_load;
  logic [3:0]              w_cur_d;
  logic                    w_cur_dp;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  seg_t                    w_dec;
  phase_e                  w_phase;
  logic                    w_blank;
  logic                    w_drive;

  assign w_slot_end = (r_cnt == CNT_LAST);
  // Load at the last cycle of the last slot, or on the first edge out of reset.
  assign w_load     = r_post_rst || (w_slot_end && (r_idx == IDX_LAST));

  // Slot counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame snapshot of digits/dp and the load strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_d     <= '0;
      r_snap_dp    <= '0;
      r_post_rst   <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_post_rst   <= 1'b0;
      r_frame_tick <= w_load;
      if (w_load) begin
        r_snap_d  <= bus.digits;
        r_snap_dp <= bus.dp_in;
      end
    end
  end

  // Select the current digit from the snapshot and its anode pattern
  always_comb begin
    w_cur_d  = '0;
    w_cur_dp = 1'b0;
    w_an_sel = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur_d     = r_snap_d[4*k +: 4];
        w_cur_dp    = r_snap_dp[k];
        w_an_sel[k] = 1'b0;
      end
    end
  end

  bcd_to_seg u_dec (
    .i_bcd (w_cur_d),
    .o_seg (w_dec)
  );

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_phase = PH_DRIVE;
    end else begin : g_guard
      assign w_phase = (r_cnt < CNT_W'(GUARD_CYCLES)) ? PH_GUARD : PH_DRIVE;
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic                  w_run;
  logic [NUM_DIGITS-1:0] w_lz;

  // Mark digits that sit in a run of zeros reaching the most significant digit
  always_comb begin
    w_run   = 1'b1;
    w_lz    = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      w_run = w_run && (r_snap_d[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      w_lz[NUM_DIGITS-1-j] = w_run;
    end
    w_blank = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k))
        w_blank = (k != 0) && w_lz[k] && !r_snap_dp[k];
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_drive = bus.en && (w_phase == PH_DRIVE) && !w_blank;

  // Registered display pins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_drive) begin
      r_an  <= w_an_sel;
      r_seg <= w_dec;
      r_dp  <= ~w_cur_dp;
    end else begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner with NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2.
// Reference model derives the display from the edge count since reset.
module tb_bcd_seg_scanner;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = ND * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits;
  logic [3:0]    dp_in;
  logic          en;

  int passed = 0;
  int total  = 0;

  int          e;
  logic [15:0] m_snap;
  logic [3:0]  m_sdp;
  int          cyc = 0;
  int          last_tick = -1;
  bit          tick_chk = 1'b0;

  bcd_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  assign bus.digits = digits;
  assign bus.dp_in  = dp_in;
  assign bus.en     = en;

  bcd_seg_scanner #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (DIV),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v < 10) return tbl[v];
    return 7'h3F;
  endfunction

  function automatic bit shown(input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    return (slot == 0) || ((m_snap >> (4 * slot)) != 16'd0) || m_sdp[slot];
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: predict outputs from current inputs and model state, then compare.
  task automatic step();
    int p, slot, c;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp, x_ft;
    x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1; x_ft = 1'b0;
    if (rst) begin
      e = 0; m_snap = '0; m_sdp = '0;
    end else begin
      e++;
      p    = (e - 1) % FRAME;
      slot = p / DIV;
      c    = p % DIV;
      if (en && c >= GUARD && shown(slot)) begin
        x_an  = ~(4'b0001 << slot);
        x_seg = ref_seg(int'((m_snap >> (4 * slot)) & 16'hF));
        x_dp  = ~m_sdp[slot];
      end
      x_ft = (e == 1) || (p == FRAME - 1);
      if (x_ft) begin
        m_snap = digits;
        m_sdp  = dp_in;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("an", 32'(bus.an), 32'(x_an));
    chk("seg", 32'(bus.seg), 32'(x_seg));
    chk("dp", 32'(bus.dp), 32'(x_dp));
    chk("frame_tick", 32'(bus.frame_tick), 32'(x_ft));
    chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    if (tick_chk && bus.frame_tick) begin
      if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'(FRAME));
      last_tick = cyc;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; digits = '0; dp_in = '0;
    e = 0; m_snap = '0; m_sdp = '0;
    repeat (3) step();

    rst = 1'b0; digits = 16'h1234; en = 1'b1;
    repeat (20) step();
    digits = 16'h5678;
    repeat (50) step();

    digits = 16'h00A9; dp_in = 4'b0010;
    repeat (70) step();

    while (e % DIV != 4) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (40) step();

    repeat (300) begin
      if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) en = ~en;
      step();
    end

    en = 1'b1;
    while (e % FRAME != 2 * DIV + 5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();

    tick_chk = 1'b1;
    last_tick = -1;
    repeat (1000) begin
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 31) == 0) dp_in = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
